// File: rtl/wtc_count_7seg.sv
// Purpose: debounced up/down/clear counter, hex or BCD, with an auto-increment timer, driving 7-segment digits.
// Latency: count updates 1 clk after the debounced button event; o_Segments follows o_Count by 1 clk.
// Backpressure: none; free-running outputs, button events are single-cycle and never queued.
module wtc_count_7seg #(
  parameter int NUM_DIGITS     = 2,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int STEP_CLKS      = 25000000,
  parameter int BLANK_LEADING  = 0
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst,
  input  logic                    i_Switch_Up,
  input  logic                    i_Switch_Down,
  input  logic                    i_Switch_Clear,
  input  logic                    i_Decimal,
  input  logic                    i_Auto,
  output logic [4*NUM_DIGITS-1:0] o_Count,
  output logic [7*NUM_DIGITS-1:0] o_Segments,
  output logic                    o_Wrap
);

  localparam int CW  = 4 * NUM_DIGITS;
  localparam int DBW = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT + 1) : 1;
  localparam int TW  = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_LIMIT - 1);
  localparam logic [TW-1:0]  TIMER_TC  = TW'(STEP_CLKS - 1);

  // Switch lanes: bit 0 = up, bit 1 = down, bit 2 = clear
  logic [2:0]          sw_raw;
  logic [2:0]          sync1;
  logic [2:0]          sync2;
  logic [2:0]          db_state;
  logic [2:0]          db_prev;
  logic [2:0][DBW-1:0] db_cnt;
  logic [2:0]          sw_evt;

  logic          up_evt;
  logic          down_evt;
  logic          clr_evt;

  logic [TW-1:0] timer;
  logic          auto_tick;

  logic          decimal_q;
  logic          mode_chg;
  logic          inc;
  logic          dec;

  logic [CW-1:0] hex_inc;
  logic [CW-1:0] hex_dec;
  logic          hex_inc_wrap;
  logic          hex_dec_wrap;
  logic [CW-1:0] bcd_inc;
  logic [CW-1:0] bcd_dec;
  logic          bcd_inc_wrap;
  logic          bcd_dec_wrap;
  logic          carry;
  logic          borrow;

  logic [7*NUM_DIGITS-1:0] seg_next;
  logic                    zero_run;

  assign sw_raw = {i_Switch_Clear, i_Switch_Down, i_Switch_Up};

  // Two-flop synchronizer for the raw buttons
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sw_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: accept a new level only after it has held for DEBOUNCE_LIMIT consecutive clocks
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      db_state <= '0;
      db_cnt   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != db_state[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_state[i] <= sync2[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          // Any bounce back to the accepted level restarts the qualification window
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // Delayed debounced level for press (rising edge) detection
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      db_prev <= '0;
    end else begin
      db_prev <= db_state;
    end
  end

  // Only presses create events; releases are ignored
  assign sw_evt   = db_state & ~db_prev;
  assign up_evt   = sw_evt[0];
  assign down_evt = sw_evt[1];
  assign clr_evt  = sw_evt[2];

  // Auto-increment timer, parked at zero while disabled so each enable starts a full period
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      timer <= '0;
    end else if (!i_Auto) begin
      timer <= '0;
    end else if (timer == TIMER_TC) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  assign auto_tick = i_Auto && (timer == TIMER_TC);

  assign mode_chg = (i_Decimal != decimal_q);
  assign inc      = up_evt | auto_tick;
  assign dec      = down_evt;

  // Binary next-values; wrap when rolling over either end of the full range
  always_comb begin
    hex_inc      = o_Count + 1'b1;
    hex_dec      = o_Count - 1'b1;
    hex_inc_wrap = &o_Count;
    hex_dec_wrap = ~|o_Count;
  end

  // BCD next-values: per-digit ripple carry/borrow from digit 0 upward
  always_comb begin
    bcd_inc = '0;
    bcd_dec = '0;
    carry   = 1'b1;
    borrow  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (!carry) begin
        bcd_inc[4*k +: 4] = o_Count[4*k +: 4];
      end else if (o_Count[4*k +: 4] >= 4'd9) begin
        bcd_inc[4*k +: 4] = 4'd0;
      end else begin
        bcd_inc[4*k +: 4] = o_Count[4*k +: 4] + 4'd1;
        carry             = 1'b0;
      end

      if (!borrow) begin
        bcd_dec[4*k +: 4] = o_Count[4*k +: 4];
      end else if (o_Count[4*k +: 4] == 4'd0) begin
        bcd_dec[4*k +: 4] = 4'd9;
      end else begin
        bcd_dec[4*k +: 4] = o_Count[4*k +: 4] - 4'd1;
        borrow            = 1'b0;
      end
    end
    // A carry/borrow out of the top digit means the whole count wrapped
    bcd_inc_wrap = carry;
    bcd_dec_wrap = borrow;
  end

  // Count register: mode change beats clear beats up/down; opposing up and down cancel
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Count   <= '0;
      o_Wrap    <= 1'b0;
      decimal_q <= 1'b0;
    end else begin
      decimal_q <= i_Decimal;
      o_Wrap    <= 1'b0;
      if (mode_chg) begin
        // A count from the other radix is meaningless, so restart from zero
        o_Count <= '0;
      end else if (clr_evt) begin
        o_Count <= '0;
      end else if (inc && !dec) begin
        o_Count <= decimal_q ? bcd_inc : hex_inc;
        o_Wrap  <= decimal_q ? bcd_inc_wrap : hex_inc_wrap;
      end else if (dec && !inc) begin
        o_Count <= decimal_q ? bcd_dec : hex_dec;
        o_Wrap  <= decimal_q ? bcd_dec_wrap : hex_dec_wrap;
      end
    end
  end

  // Active-high segment pattern for one hex digit, bit 0 = A .. bit 6 = G
  function automatic logic [6:0] seg_hex(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h3F;
      4'h1:    s = 7'h06;
      4'h2:    s = 7'h5B;
      4'h3:    s = 7'h4F;
      4'h4:    s = 7'h66;
      4'h5:    s = 7'h6D;
      4'h6:    s = 7'h7D;
      4'h7:    s = 7'h07;
      4'h8:    s = 7'h7F;
      4'h9:    s = 7'h6F;
      4'hA:    s = 7'h77;
      4'hB:    s = 7'h7C;
      4'hC:    s = 7'h39;
      4'hD:    s = 7'h5E;
      4'hE:    s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Decode every digit, walking down from the top so zero_run knows whether all higher digits are zero
  always_comb begin
    seg_next = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (o_Count[4*k +: 4] == 4'd0);
      if ((BLANK_LEADING != 0) && (k > 0) && zero_run) begin
        seg_next[7*k +: 7] = 7'h7F;
      end else begin
        seg_next[7*k +: 7] = ~seg_hex(o_Count[4*k +: 4]);
      end
    end
  end

  // Registered segment outputs; reset shows a zero count (blanked above digit 0 if enabled)
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        o_Segments[7*k +: 7] <= ((BLANK_LEADING != 0) && (k > 0)) ? 7'h7F : 7'h40;
      end
    end else begin
      o_Segments <= seg_next;
    end
  end

endmodule

// File: tb/tb_wtc_count_7seg.sv
// Purpose: directed checks of debounce, hex/BCD arithmetic, wrap, event priority and segment decode/blanking.
// Latency: inputs driven 1 time unit after a rising edge, outputs sampled at the same point.
// Backpressure: none; two instances (no blanking / blanking) share all inputs.
module tb_wtc_count_7seg;

  logic        clk      = 1'b0;
  logic        rst      = 1'b1;
  logic        sw_up    = 1'b0;
  logic        sw_down  = 1'b0;
  logic        sw_clear = 1'b0;
  logic        decimal  = 1'b0;
  logic        auto_en  = 1'b0;

  logic [7:0]  count;
  logic [7:0]  count_b;
  logic [13:0] seg;
  logic [13:0] seg_b;
  logic        wrap;
  logic        wrap_b;

  int          checks   = 0;
  int          errors   = 0;
  int          wrap_cnt = 0;
  logic [7:0]  wrap_val = '0;

  always #5 clk = ~clk;

  wtc_count_7seg #(
    .NUM_DIGITS(2), .DEBOUNCE_LIMIT(4), .STEP_CLKS(8), .BLANK_LEADING(0)
  ) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Switch_Up(sw_up), .i_Switch_Down(sw_down),
    .i_Switch_Clear(sw_clear), .i_Decimal(decimal), .i_Auto(auto_en),
    .o_Count(count), .o_Segments(seg), .o_Wrap(wrap)
  );

  wtc_count_7seg #(
    .NUM_DIGITS(2), .DEBOUNCE_LIMIT(4), .STEP_CLKS(8), .BLANK_LEADING(1)
  ) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_Switch_Up(sw_up), .i_Switch_Down(sw_down),
    .i_Switch_Clear(sw_clear), .i_Decimal(decimal), .i_Auto(auto_en),
    .o_Count(count_b), .o_Segments(seg_b), .o_Wrap(wrap_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and record any wrap pulse seen
  task automatic tick();
    @(posedge clk);
    #1;
    if (wrap) begin
      wrap_cnt++;
      wrap_val = count;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input logic u, input logic d, input logic c, input int hold);
    sw_up    = u;
    sw_down  = d;
    sw_clear = c;
    run(hold);
    sw_up    = 1'b0;
    sw_down  = 1'b0;
    sw_clear = 1'b0;
    run(12);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset state
    run(3);
    check_val("rst_count", count, 8'h00);
    check_val("rst_seg", seg, 14'h2040);
    check_val("rst_seg_blank", seg_b, 14'h3FC0);
    check_val("rst_wrap", wrap, 1'b0);
    check_val("rst_wrap_b", wrap_b, 1'b0);
    rst = 1'b0;
    run(2);

    // Hex auto count to 0x37 (55 ticks of 8 clocks), then asynchronous reset mid-cycle
    auto_en = 1'b1;
    run(440);
    auto_en = 1'b0;
    check_val("auto_hex_37", count, 8'h37);
    run(2);
    check_val("seg_37", seg, 14'h1878);
    check_val("count_b_37", count_b, 8'h37);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_count", count, 8'h00);
    check_val("async_rst_seg", seg, 14'h2040);
    check_val("async_rst_seg_blank", seg_b, 14'h3FC0);
    check_val("async_rst_wrap", wrap, 1'b0);
    tick();
    rst = 1'b0;
    run(2);

    // Debounce: 3-clock pulses are rejected, a 10-clock hold counts once
    for (int p = 0; p < 3; p++) begin
      sw_up = 1'b1;
      run(3);
      sw_up = 1'b0;
      run(5);
    end
    run(10);
    check_val("short_pulses", count, 8'h00);
    press(1'b1, 1'b0, 1'b0, 10);
    check_val("up_held", count, 8'h01);
    check_val("seg_digit0_1", seg[6:0], 7'h79);
    check_val("seg_blank_01", seg_b, 14'h3FF9);
    run(20);
    check_val("release_no_change", count, 8'h01);

    // Hex wrap in both directions
    press(1'b0, 1'b0, 1'b1, 10);
    check_val("clear", count, 8'h00);
    wrap_cnt = 0;
    press(1'b0, 1'b1, 1'b0, 10);
    check_val("hex_down_wrap", count, 8'hFF);
    check_val("hex_down_wrap_pulses", wrap_cnt, 1);
    check_val("hex_down_wrap_val", wrap_val, 8'hFF);
    check_val("seg_FF", seg, 14'h070E);
    wrap_cnt = 0;
    press(1'b1, 1'b0, 1'b0, 10);
    check_val("hex_up_wrap", count, 8'h00);
    check_val("hex_up_wrap_pulses", wrap_cnt, 1);
    check_val("hex_up_wrap_val", wrap_val, 8'h00);

    // Simultaneous events from 0x42 (66 auto ticks)
    auto_en = 1'b1;
    run(528);
    auto_en = 1'b0;
    check_val("auto_hex_42", count, 8'h42);
    press(1'b1, 1'b1, 1'b0, 10);
    check_val("up_down_cancel", count, 8'h42);
    wrap_cnt = 0;
    press(1'b1, 1'b0, 1'b1, 10);
    check_val("clear_beats_up", count, 8'h00);
    check_val("clear_no_wrap", wrap_cnt, 0);

    // Auto tick lands on the same edge as the down event: they cancel, no wrap from 0
    wrap_cnt = 0;
    auto_en  = 1'b1;
    tick();
    sw_down  = 1'b1;
    run(7);
    auto_en  = 1'b0;
    run(5);
    sw_down  = 1'b0;
    run(12);
    check_val("tick_down_cancel", count, 8'h00);
    check_val("tick_down_no_wrap", wrap_cnt, 0);

    // Leading-zero blanking
    auto_en = 1'b1;
    run(40);
    auto_en = 1'b0;
    run(2);
    check_val("count_05", count, 8'h05);
    check_val("blank_05", seg_b, 14'h3F92);
    check_val("noblank_05", seg, 14'h2012);
    press(1'b0, 1'b0, 1'b1, 10);
    check_val("blank_00", seg_b, 14'h3FC0);
    auto_en = 1'b1;
    run(640);
    auto_en = 1'b0;
    run(2);
    check_val("count_50", count, 8'h50);
    check_val("blank_50", seg_b, 14'h0940);

    // Switch to BCD: count clears on the next edge, then 100 auto ticks wrap 99 -> 00
    decimal = 1'b1;
    tick();
    check_val("mode_clear", count, 8'h00);
    check_val("mode_clear_b", count_b, 8'h00);
    wrap_cnt = 0;
    auto_en  = 1'b1;
    for (int i = 1; i <= 805; i++) begin
      tick();
      check_val("bcd_count", count, to_bcd((i / 8) % 100));
      check_val("bcd_wrap", wrap, (i == 800) ? 1'b1 : 1'b0);
    end
    auto_en = 1'b0;
    check_val("bcd_wrap_pulses", wrap_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
